// File: rtl/program_sequencer.sv
// Program RAM and fetch sequencer feeding the processor's external data input.
// Optional retired-instruction counter built when SEQ_RETIRE_COUNT_EN is defined.
module program_sequencer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4,
  parameter int unsigned DATA_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load_en,
  input  logic [AW-1:0]     i_load_addr,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_run,
  input  logic              i_ext,
  input  logic              i_irin,
  input  logic              i_clr,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_proc_en,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_wrap_err,
  output logic [AW-1:0]     o_pc,
  output logic [15:0]       o_instr_count
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e              r_state;
  logic [AW-1:0]       r_pc;
  logic                r_wrap_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_running;
  logic [DATA_W-1:0]   w_word;
  logic                w_halt_word;
  logic                w_pc_last;
  logic                w_start;

  assign w_running   = (r_state == StRun);
  assign w_word      = r_mem[r_pc];
  // Opcode class 2'b01 is unused by the ISA and doubles as the stop marker.
  assign w_halt_word = (w_word[DATA_W-1 -: 2] == 2'b01);
  assign w_pc_last   = (r_pc == AW'(DEPTH - 1));
  assign w_start     = i_run && !w_running;

  always_ff @(posedge i_clk) begin
    if (i_load_en && !w_running) begin
      r_mem[i_load_addr] <= i_load_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_pc       <= '0;
      r_wrap_err <= 1'b0;
    end else begin
      case (r_state)
        StIdle, StHalt: begin
          if (i_run) begin
            r_pc       <= '0;
            r_wrap_err <= 1'b0;
            r_state    <= StRun;
          end
        end
        StRun: begin
          if (i_ext) begin
            if (i_irin && w_halt_word) begin
              r_state <= StHalt;
            end else begin
              r_pc <= r_pc + AW'(1);
              if (w_pc_last) begin
                r_wrap_err <= 1'b1;
              end
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef SEQ_RETIRE_COUNT_EN
  logic [15:0] r_instr_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || w_start) begin
      r_instr_count <= '0;
    end else if (w_running && i_clr && (r_instr_count != 16'hFFFF)) begin
      r_instr_count <= r_instr_count + 16'd1;
    end
  end

  assign o_instr_count = r_instr_count;
`else
  logic w_unused_clr;
  assign w_unused_clr  = i_clr;
  assign o_instr_count = 16'd0;
`endif

  assign o_data_out = w_running ? w_word : '0;
  assign o_proc_en  = w_running;
  assign o_busy     = w_running;
  assign o_done     = (r_state == StHalt);
  assign o_wrap_err = r_wrap_err;
  assign o_pc       = r_pc;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer (fetch, halt, load gating, wrap, reset).
module tb_program_sequencer;

  logic        clk = 1'b0;
  logic        rst, load_en, run, ext, irin, clr;
  logic [3:0]  load_addr;
  logic [9:0]  load_data;
  logic [9:0]  data_out;
  logic        proc_en, busy, done, wrap_err;
  logic [3:0]  pc;
  logic [15:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SEQ_RETIRE_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  program_sequencer #(.DEPTH(16), .AW(4), .DATA_W(10)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_load_en     (load_en),
    .i_load_addr   (load_addr),
    .i_load_data   (load_data),
    .i_run         (run),
    .i_ext         (ext),
    .i_irin        (irin),
    .i_clr         (clr),
    .o_data_out    (data_out),
    .o_proc_en     (proc_en),
    .o_busy        (busy),
    .o_done        (done),
    .o_wrap_err    (wrap_err),
    .o_pc          (pc),
    .o_instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [9:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic consume(input logic with_irin);
    ext  = 1'b1;
    irin = with_irin;
    tick();
    ext  = 1'b0;
    irin = 1'b0;
  endtask

  function automatic logic [15:0] exp_cnt(input int n);
    return CntEn ? 16'(n) : 16'd0;
  endfunction

  initial begin
    rst = 1'b1; load_en = 1'b0; run = 1'b0; ext = 1'b0; irin = 1'b0; clr = 1'b0;
    load_addr = '0; load_data = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pc", pc, 0);
    check("rst_proc_en", proc_en, 0);
    check("rst_data", data_out, 0);
    check("rst_wrap", wrap_err, 0);
    check("rst_cnt", instr_count, 0);

    // ld R1 / operand / HALT
    load(4'd0, 10'h000);
    load(4'd1, 10'h005);
    load(4'd2, 10'h100);
    run = 1'b1; tick(); run = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_proc_en", proc_en, 1);
    check("t1_data0", data_out, 10'h000);
    consume(1'b1);
    check("t1_data1", data_out, 10'h005);
    consume(1'b0);
    check("t1_data2", data_out, 10'h100);
    consume(1'b1);
    check("t1_done", done, 1);
    check("t1_pc", pc, 2);
    check("t1_proc_en_off", proc_en, 0);
    check("t1_data_halt", data_out, 0);

    // Retire counting, load gating, run ignored while busy
    load(4'd0, 10'h201);
    load(4'd1, 10'h000);
    load(4'd2, 10'h000);
    load(4'd3, 10'h0AB);
    load(4'd4, 10'h003);
    load(4'd5, 10'h100);
    run = 1'b1; tick(); run = 1'b0;
    check("t2_pc0", pc, 0);
    consume(1'b1);
    load(4'd3, 10'h2AA);
    tick(); tick();
    clr = 1'b1; tick(); clr = 1'b0;
    check("t2_pc1", pc, 1);
    check("t2_cnt1", instr_count, exp_cnt(1));
    ext = 1'b1; irin = 1'b1; clr = 1'b1; tick();
    ext = 1'b0; irin = 1'b0; clr = 1'b0;
    check("t2_pc2", pc, 2);
    check("t2_cnt2", instr_count, exp_cnt(2));
    consume(1'b1);
    check("t2_mem3_kept", data_out, 10'h0AB);
    consume(1'b1);
    run = 1'b1; tick(); run = 1'b0;
    check("t2_run_ign_pc", pc, 4);
    check("t2_run_ign_busy", busy, 1);
    check("t2_run_ign_cnt", instr_count, exp_cnt(2));
    consume(1'b1);
    check("t2_pc5", pc, 5);
    check("t2_data5", data_out, 10'h100);
    consume(1'b1);
    check("t2_done", done, 1);
    check("t2_pc_halt", pc, 5);
    clr = 1'b1; tick(); clr = 1'b0;
    check("t2_clr_halt", instr_count, exp_cnt(2));

    // Load and run in the same cycle from HALT
    load_en = 1'b1; load_addr = 4'd3; load_data = 10'h2AA; run = 1'b1;
    tick();
    load_en = 1'b0; run = 1'b0;
    check("t3_pc0", pc, 0);
    check("t3_cnt0", instr_count, 0);
    irin = 1'b1; tick(); irin = 1'b0;
    check("t3_irin_only", pc, 0);
    consume(1'b1);
    consume(1'b0);
    consume(1'b1);
    check("t3_mem3_new", data_out, 10'h2AA);

    // Reset colliding with a fetch
    rst = 1'b1; ext = 1'b1; irin = 1'b1;
    tick();
    rst = 1'b0; ext = 1'b0; irin = 1'b0;
    check("t4_busy", busy, 0);
    check("t4_pc", pc, 0);
    check("t4_proc_en", proc_en, 0);
    check("t4_data", data_out, 0);
    ext = 1'b1; irin = 1'b1; tick(); ext = 1'b0; irin = 1'b0;
    check("t4_ext_idle", pc, 0);

    // Wrap: HALT at 1 is consumed as an operand first time round
    for (int i = 0; i < 16; i++) load(4'(i), (i == 1) ? 10'h100 : 10'h000);
    run = 1'b1; tick(); run = 1'b0;
    for (int i = 0; i < 15; i++) consume(i != 1);
    check("t5_pc15", pc, 15);
    check("t5_wrap_pre", wrap_err, 0);
    consume(1'b1);
    check("t5_pc_wrap", pc, 0);
    check("t5_wrap_set", wrap_err, 1);
    check("t5_busy", busy, 1);
    consume(1'b1);
    consume(1'b1);
    check("t5_done", done, 1);
    check("t5_wrap_sticky", wrap_err, 1);
    run = 1'b1; tick(); run = 1'b0;
    check("t5_wrap_clr", wrap_err, 0);
    check("t5_pc_restart", pc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
